spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sclk_div.sv | 18 +
 rtl/spi_xfer_ctrl.sv | 108 ++++++++++
 tb/tb_spi_xfer_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, divider constants and frame-length default
// for the SPI transfer controller.
package spi_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W = 5;
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;
    localparam logic [CNT_W-1:0] DIV_0   = 5'd1;
    localparam logic [CNT_W-1:0] DIV_1   = 5'd4;
    localparam logic [CNT_W-1:0] DIV_2   = 5'd8;
    localparam logic [CNT_W-1:0] DIV_3   = 5'd16;
    localparam logic [CNT_W-1:0] DIV_DEF = 5'd4;
    function automatic logic [CNT_W-1:0] div_map(input logic [2:0] sel);
        return sel == 3'd0 ? DIV_0 : sel == 3'd1 ? DIV_1 : sel == 3'd2 ? DIV_2 :
               sel == 3'd3 ? DIV_3 : DIV_DEF;
    endfunction
endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: half-period counter; stb marks the last of div+1 enabled cycles.
module spi_sclk_div
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             stb
);
    logic [CNT_W-1:0] cnt;
    assign stb = en && cnt == div;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (en && !stb && !clr) ? cnt + CNT_W'(1) : '0;
    end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master for one DATA_W-bit frame with selectable
// SCLK rate, polarity and phase.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [2:0]        divider,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);
    localparam int TW = $clog2(2 * DATA_W + 1);
    localparam logic [TW-1:0] LAST = TW'(2 * DATA_W - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  div_q;
    logic              cpol_q, cpha_q, stb, div_en, lead, last_tgl, xfer_stb, do_shift, do_sample;
    logic [TW-1:0]     tgl;
    logic [DATA_W-1:0] tx_sr, rx_sr;

    assign div_en    = state == SETUP || state == XFER || state == HOLD;
    assign lead      = !tgl[0];
    assign last_tgl  = tgl == LAST;
    assign xfer_stb  = state == XFER && stb;
    // cpha=0 already presented the MSB at start, so trailing toggles shift except the final one
    assign do_shift  = xfer_stb && (cpha_q ? lead : (!lead && !last_tgl));
    assign do_sample = xfer_stb && (cpha_q ? !lead : lead);

    spi_sclk_div u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (div_en),
        .clr  (state != state_nx),
        .div  (div_q),
        .stb  (stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SETUP : IDLE;
            SETUP:   state_nx = stb ? XFER : SETUP;
            XFER:    state_nx = (stb && last_tgl) ? HOLD : XFER;
            HOLD:    state_nx = stb ? DONE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cs_n = !div_en;
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tgl     <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                sclk <= cpol;
                if (start) begin
                    div_q  <= div_map(divider);
                    cpol_q <= cpol;
                    cpha_q <= cpha;
                    tgl    <= '0;
                    rx_sr  <= '0;
                    tx_sr  <= cpha ? tx_data : tx_data << 1;
                    if (!cpha) mosi <= tx_data[DATA_W-1];
                end
            end
            if (xfer_stb) begin
                sclk <= ~sclk;
                tgl  <= tgl + TW'(1);
            end
            if (state == HOLD) sclk <= cpol_q;
            if (do_shift) begin
                mosi  <= tx_sr[DATA_W-1];
                tx_sr <= tx_sr << 1;
            end
            if (do_sample) rx_sr <= {rx_sr[DATA_W-2:0], miso};
            if (state == HOLD && stb) rx_data <= rx_sr;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed scenarios with a done-driven scoreboard monitor.
module tb_spi_xfer_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] divider = 3'd0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       miso;
    logic       loop = 1'b0;
    logic       miso_c = 1'b0;
    logic       sclk, mosi, cs_n, busy, done;
    logic [7:0] rx_data;

    typedef struct {
        logic [7:0] rx;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, rises = 0, falls = 0, done_cnt = 0;
    int r0, f0, d0;
    logic       sclk_p = 1'b0;
    logic [7:0] mseq = 8'h00;

    assign miso = loop ? mosi : miso_c;

    spi_xfer_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .tx_data(tx_data),
        .divider(divider),
        .cpol   (cpol),
        .cpha   (cpha),
        .miso   (miso),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs_n   (cs_n),
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", int'(rx_data), int'(e.rx));
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (!cs_n && sclk && !sclk_p) rises++;
        if (!cs_n && !sclk && sclk_p) begin
            falls++;
            mseq = {mseq[6:0], mosi};
        end
        sclk_p = sclk;
    end

    task automatic start_xfer(input logic [7:0] tx, input logic [2:0] dv, input logic pol,
                              input logic pha, input logic hold);
        @(negedge clk);
        tx_data = tx;
        divider = dv;
        cpol = pol;
        cpha = pha;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        t0 = cyc;
        r0 = rises;
        f0 = falls;
        d0 = done_cnt;
    endtask

    task automatic push(input logic [7:0] rx, input int at);
        exp_t e;
        e.rx = rx;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int limit, input string name);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check(name, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rx", int'(rx_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0, H=2, loopback
        loop = 1'b1;
        start_xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0);
        push(8'hA5, t0 + 36);
        check("setup_mosi_msb", int'(mosi), 1);
        check("setup_busy", int'(busy), 1);
        check("setup_cs_n", int'(cs_n), 0);
        wait_done(100, "t1_timeout");
        check("t1_rises", rises - r0, 8);

        // mode 3, H=5, miso high
        loop = 1'b0;
        miso_c = 1'b1;
        @(negedge clk);
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_idle_high_before", int'(sclk), 1);
        start_xfer(8'h3C, 3'd1, 1'b1, 1'b1, 1'b0);
        push(8'hFF, t0 + 90);
        wait_done(200, "t2_timeout");
        check("t2_falls", falls - f0, 8);
        check("t2_mosi_seq", int'(mseq), 8'h3C);
        repeat (2) @(negedge clk);
        check("t2_idle_high_after", int'(sclk), 1);

        // divider 5 aliases to H=5
        loop = 1'b1;
        start_xfer(8'h5A, 3'd5, 1'b0, 1'b0, 1'b0);
        push(8'h5A, t0 + 90);
        wait_done(200, "t3_timeout");

        // divider 3: H=17
        start_xfer(8'hC3, 3'd3, 1'b0, 1'b0, 1'b0);
        push(8'hC3, t0 + 306);
        wait_done(400, "t4_timeout");

        // start re-pulse mid-transfer is ignored
        start_xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0);
        push(8'hA5, t0 + 36);
        repeat (9) @(negedge clk);
        start = 1'b1;
        tx_data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, "t5_timeout");
        repeat (5) @(negedge clk);
        check("t5_single_done", done_cnt - d0, 1);
        check("t5_idle_busy", int'(busy), 0);

        // reset during bit 4 of the frame
        start_xfer(8'hFF, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t6_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6_cs_n", int'(cs_n), 1);
        check("t6_sclk", int'(sclk), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_mosi", int'(mosi), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_busy", int'(busy), 0);
        check("t6_post_cs_n", int'(cs_n), 1);
        check("t6_no_done", done_cnt - d0, 0);

        // recovery frame, mode 1 loopback
        start_xfer(8'h96, 3'd0, 1'b0, 1'b1, 1'b0);
        push(8'h96, t0 + 36);
        wait_done(100, "t7_timeout");

        // start held through DONE: back-to-back frames with one idle cycle
        start_xfer(8'h11, 3'd0, 1'b0, 1'b0, 1'b1);
        push(8'h11, t0 + 36);
        push(8'h11, t0 + 74);
        wait_done(100, "t8a_timeout");
        @(negedge clk);
        check("t8_idle_gap", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check("t8_restart_busy", int'(busy), 1);
        wait_done(100, "t8b_timeout");
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
